// File: rtl/or_fe_pkg.sv
// Package: or_fe_pkg
// Shared types and constants for the bit-serial OR-core front end.
//   or_fe_state_t : front-end FSM state encoding
//   OR_FE_WIDTH   : default operand/result width
//   send_bits()   : serial result length for a given width
//   SEND_BITS     : serial result length at the default width
// Optional feature macro: OR_FE_PARITY_EN (appends an even-parity bit to the result stream).
package or_fe_pkg;

  localparam int OR_FE_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    CAPTURE,
    SEND,
    DONE
  } or_fe_state_t;

  // Number of bits shifted out in SEND for a given operand width.
  function automatic int send_bits(input int width);
`ifdef OR_FE_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

  localparam int SEND_BITS = send_bits(OR_FE_WIDTH);

endpackage

// File: rtl/or_fe_shreg.sv
// Module: or_fe_shreg
// WIDTH-bit MSB-first shift register with parallel load.
//   clk      in   1      clock, rising edge
//   rst_n    in   1      asynchronous active-low reset (clears q)
//   load     in   1      parallel load of load_val (has priority over shift)
//   load_val in   WIDTH  parallel load value
//   shift_en in   1      shift left one place, sin enters at bit 0
//   sin      in   1      serial input
//   q        out  WIDTH  register contents
// Optional feature macro: none.
module or_fe_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift_en,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] shift_next;

  // Each bit takes its lower neighbour; bit 0 takes the serial input.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (gi == 0) begin : g_lsb
        assign shift_next[gi] = sin;
      end else begin : g_upper
        assign shift_next[gi] = q_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg <= '0;
    end else if (load) begin
      q_reg <= load_val;
    end else if (shift_en) begin
      q_reg <= shift_next;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/or_serial_frontend.sv
// Module: or_serial_frontend
// Bit-serial front end for the OR core: shifts in operand A then B (MSB first),
// presents them to the core, captures the core result and shifts it out MSB first
// under a valid/ready handshake.
//   clk         in   1      clock, rising edge
//   rst_n       in   1      asynchronous active-low reset
//   start       in   1      begin a transaction (only looked at in IDLE)
//   sin         in   1      serial operand data, MSB first
//   sin_valid   in   1      sin qualifier, one bit per high cycle
//   core_a      out  WIDTH  operand A to the core
//   core_b      out  WIDTH  operand B to the core
//   core_y      in   WIDTH  core result
//   sout        out  1      serial result, MSB first
//   sout_valid  out  1      sout carries a result bit
//   sout_ready  in   1      consumer accepts the bit when sout_valid is also high
//   busy        out  1      high outside IDLE
//   done        out  1      one-cycle pulse after the last result bit is accepted
// Optional feature macro: OR_FE_PARITY_EN -- an even-parity bit (^result) follows
// the WIDTH result bits.
module or_serial_frontend
  import or_fe_pkg::*;
#(
  parameter int WIDTH = OR_FE_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sin,
  input  logic             sin_valid,
  output logic [WIDTH-1:0] core_a,
  output logic [WIDTH-1:0] core_b,
  input  logic [WIDTH-1:0] core_y,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_LOAD = CNT_W'(WIDTH - 1);
  // Count value during the final SEND bit (the parity bit when enabled), so the
  // counter tops out at WIDTH.
  localparam logic [CNT_W-1:0] LAST_SEND = CNT_W'(send_bits(WIDTH) - 1);

  or_fe_state_t     state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             shift_a, shift_b, shift_r, load_r;
  logic [WIDTH-1:0] result_q;

  or_fe_shreg #(.WIDTH(WIDTH)) u_reg_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (1'b0),
    .load_val('0),
    .shift_en(shift_a),
    .sin     (sin),
    .q       (core_a)
  );

  or_fe_shreg #(.WIDTH(WIDTH)) u_reg_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (1'b0),
    .load_val('0),
    .shift_en(shift_b),
    .sin     (sin),
    .q       (core_b)
  );

  // Result is loaded from the core in CAPTURE and drained MSB first in SEND.
  or_fe_shreg #(.WIDTH(WIDTH)) u_reg_result (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load_r),
    .load_val(core_y),
    .shift_en(shift_r),
    .sin     (1'b0),
    .q       (result_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    shift_a    = 1'b0;
    shift_b    = 1'b0;
    shift_r    = 1'b0;
    load_r     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = LOAD_A;
          cnt_next   = '0;
        end
      end
      LOAD_A: begin
        if (sin_valid) begin
          shift_a = 1'b1;
          if (cnt_reg == LAST_LOAD) begin
            state_next = LOAD_B;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      LOAD_B: begin
        if (sin_valid) begin
          shift_b = 1'b1;
          if (cnt_reg == LAST_LOAD) begin
            state_next = CAPTURE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      CAPTURE: begin
        load_r     = 1'b1;
        state_next = SEND;
        cnt_next   = '0;
      end
      SEND: begin
        // sout_valid is constantly high here, so ready alone marks a handshake.
        if (sout_ready) begin
          shift_r = 1'b1;
          if (cnt_reg == LAST_SEND) begin
            state_next = DONE;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

`ifdef OR_FE_PARITY_EN
  localparam logic [CNT_W-1:0] PARITY_SLOT = CNT_W'(WIDTH);

  // Parity is taken from the full result before shifting destroys it.
  logic parity_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_reg <= 1'b0;
    end else if (load_r) begin
      parity_reg <= ^core_y;
    end
  end
`endif

  always_comb begin
    sout = 1'b0;
    if (state_reg == SEND) begin
      sout = result_q[WIDTH-1];
`ifdef OR_FE_PARITY_EN
      if (cnt_reg == PARITY_SLOT) begin
        sout = parity_reg;
      end
`endif
    end
  end

  assign sout_valid = (state_reg == SEND);
  assign busy       = (state_reg != IDLE);
  assign done       = (state_reg == DONE);

endmodule

// File: tb/tb_or_serial_frontend.sv
// Testbench: tb_or_serial_frontend
// Scoreboard bench for or_serial_frontend at WIDTH=8. The OR core is modelled as
// core_a|core_b. Each transaction pushes its expected serial bits into a queue; a
// monitor compares every presented sout bit against the queue head and pops on
// handshake. Parity expectation follows or_fe_pkg::SEND_BITS.
module tb_or_serial_frontend;

  localparam int W = 8;
  localparam bit PARITY = (or_fe_pkg::SEND_BITS == W + 1);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sin = 1'b0;
  logic         sin_valid = 1'b0;
  logic         sout_ready = 1'b0;
  logic [W-1:0] core_a, core_b, core_y;
  logic         sout, sout_valid, busy, done;

  or_serial_frontend #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sin       (sin),
    .sin_valid (sin_valid),
    .core_a    (core_a),
    .core_b    (core_b),
    .core_y    (core_y),
    .sout      (sout),
    .sout_valid(sout_valid),
    .sout_ready(sout_ready),
    .busy      (busy),
    .done      (done)
  );

  assign core_y = core_a | core_b;

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit exp_bits[$];
  int exp_done = 0;
  int cyc = 0;
  int first_valid_cyc = -1;
  int start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares each presented bit with the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sout_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (exp_bits.size() == 0) begin
          check("sout_valid with nothing expected", 32'(sout_valid), 32'd0);
        end else begin
          check("sout bit", 32'(sout), 32'(exp_bits[0]));
          if (sout_ready) void'(exp_bits.pop_front());
        end
      end
      if (done) begin
        check("done outstanding txn", 32'(exp_done), 32'd1);
        check("bits left at done", 32'(exp_bits.size()), 32'd0);
        check("sout_valid during done", 32'(sout_valid), 32'd0);
        exp_done = 0;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, " sout_valid"}, 32'(sout_valid), 32'd0);
    check({tag, " sout"}, 32'(sout), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " core_a"}, 32'(core_a), 32'd0);
    check({tag, " core_b"}, 32'(core_b), 32'd0);
  endtask

  // ready_mode: 0 always ready, 1 stall 3 cycles mid-SEND, 2 random.
  // gap_mode: 0 none, 1 valid every other cycle, 2 random gaps.
  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input int gap_mode,
                         input int ready_mode, input bit glitch, input bit start_bit,
                         input int abort_after, input bit check_lat);
    logic [7:0] y;
    int hs;
    bit ok;
    bit hs_now;
    y = a | b;
    for (int i = W - 1; i >= 0; i--) exp_bits.push_back(y[i]);
    if (PARITY) exp_bits.push_back(^y);
    exp_done++;
    first_valid_cyc = -1;

    start = 1'b1;
    sin_valid = start_bit;
    sin = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
    sin_valid = 1'b0;

    for (int i = 0; i < 2 * W; i++) begin
      if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
        sin = 1'($urandom);
        sin_valid = 1'b0;
        tick();
      end
      sin = (i < W) ? a[W-1-i] : b[2*W-1-i];
      sin_valid = 1'b1;
      start = glitch && (i == 11);
      tick();
      sin_valid = 1'b0;
      start = 1'b0;
    end
    sin = 1'($urandom);

    ok = 1'b0;
    hs = 0;
    for (int j = 0; j < 300 && !ok; j++) begin
      case (ready_mode)
        0: sout_ready = 1'b1;
        1: sout_ready = !(j >= 5 && j < 8);
        default: sout_ready = ($urandom_range(0, 3) != 0);
      endcase
      start = glitch && (j == 4);
      hs_now = sout_valid && sout_ready;
      tick();
      start = 1'b0;
      if (hs_now) hs++;
      if (abort_after > 0 && hs == abort_after) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid-send reset");
        exp_bits.delete();
        exp_done = 0;
        sout_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("idle after reset busy", 32'(busy), 32'd0);
        return;
      end
      if (done) ok = 1'b1;
    end
    if (!ok) check("done within cycle budget", 32'd0, 32'd1);
    if (check_lat) check("start to first sout_valid cycles", 32'(first_valid_cyc - start_cyc), 32'd18);
    tick();
    check("done single cycle", 32'(done), 32'd0);
    check("busy after txn", 32'(busy), 32'd0);
    check("core_a holds A", 32'(core_a), 32'(a));
    check("core_b holds B", 32'(core_b), 32'(b));
    $display("txn A=%02h B=%02h result=%02h gap=%0d ready=%0d glitch=%0b startbit=%0b",
             a, b, y, gap_mode, ready_mode, glitch, start_bit);
  endtask

  initial begin
    #1;
    check_reset_outputs("power-on reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // sin_valid and sout_ready while idle must not start or emit anything.
    for (int i = 0; i < 3; i++) begin
      sin_valid = 1'b1;
      sin = 1'b1;
      sout_ready = 1'b1;
      tick();
      check("idle ignores sin_valid busy", 32'(busy), 32'd0);
      check("idle sout_valid", 32'(sout_valid), 32'd0);
    end
    sin_valid = 1'b0;
    check("idle core_a untouched", 32'(core_a), 32'd0);

    run_txn(8'hA5, 8'h5A, 0, 0, 1'b0, 1'b0, 0, 1'b1);
    run_txn(8'h80, 8'h01, 1, 0, 1'b0, 1'b0, 0, 1'b0);
    run_txn(8'h0F, 8'h30, 0, 1, 1'b0, 1'b0, 0, 1'b0);
    run_txn(8'hC3, 8'h14, 0, 0, 1'b1, 1'b0, 0, 1'b0);
    run_txn(8'hB6, 8'h49, 0, 0, 1'b0, 1'b0, 5, 1'b0);
    run_txn(8'h00, 8'h00, 0, 0, 1'b0, 1'b0, 0, 1'b0);
    run_txn(8'h3C, 8'h41, 0, 0, 1'b0, 1'b1, 0, 1'b0);

    for (int k = 0; k < 10; k++) begin
      run_txn(8'($urandom), 8'($urandom), $urandom_range(0, 2), 2, 1'($urandom), 1'($urandom), 0, 1'b0);
    end

    check("scoreboard drained", 32'(exp_bits.size()), 32'd0);
    check("no outstanding done", 32'(exp_done), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
